id_ex_skid: RTL and testbench

Parametrised decode→execute pipeline stage with valid/ready handshaking, a one-entry skid buffer, synchronous flush, and a saturating bubble counter. It sits between the decode and execute stages. It replaces the free-running stage register so that execute can stall decode without losing an instruction, and a branch or exception can squash the stage. When the stage is empty, the payload outputs carry NOP encodings so execute always sees a harmless operation.

---
 rtl/id_ex_skid.sv | 130 +++++++++++++
 tb/tb_id_ex_skid.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid.sv
// id_ex_skid: decode->execute pipeline stage with valid/ready handshake, a one-entry
// skid buffer, synchronous flush and a saturating bubble counter.
//
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   flush_i             squash every instruction held in the stage
//   id_valid_i/id_ready_o, id_*_i   decode-side handshake and payload
//   ex_valid_o/ex_ready_i, ex_*_o   execute-side handshake and registered payload
//   bubble_cnt_o        saturating count of cycles with ex_valid_o low since reset
//
// While the stage is empty, ex_*_o carries a NOP encoding so execute always sees a
// harmless operation.
module id_ex_skid #(
  parameter int unsigned ALUSEL_W   = 3,
  parameter int unsigned ALUOP_W    = 8,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NOP_ALUSEL = 0,
  parameter int unsigned NOP_ALUOP  = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                id_valid_i,
  output logic                id_ready_o,
  input  logic [ALUSEL_W-1:0] id_alusel_i,
  input  logic [ALUOP_W-1:0]  id_aluop_i,
  input  logic                id_wreg_i,
  input  logic [ADDR_W-1:0]   id_waddr_i,
  input  logic [DATA_W-1:0]   id_reg1_i,
  input  logic [DATA_W-1:0]   id_reg2_i,
  output logic                ex_valid_o,
  input  logic                ex_ready_i,
  output logic [ALUSEL_W-1:0] ex_alusel_o,
  output logic [ALUOP_W-1:0]  ex_aluop_o,
  output logic                ex_wreg_o,
  output logic [ADDR_W-1:0]   ex_waddr_o,
  output logic [DATA_W-1:0]   ex_reg1_o,
  output logic [DATA_W-1:0]   ex_reg2_o,
  output logic [CNT_W-1:0]    bubble_cnt_o
);

  localparam int unsigned PayW = ALUSEL_W + ALUOP_W + 1 + ADDR_W + 2 * DATA_W;

  localparam logic [ALUSEL_W-1:0] NopAlusel = ALUSEL_W'(NOP_ALUSEL);
  localparam logic [ALUOP_W-1:0]  NopAluop  = ALUOP_W'(NOP_ALUOP);
  localparam logic [PayW-1:0]     BubblePay = {NopAlusel, NopAluop, 1'b0,
                                               {ADDR_W{1'b0}}, {(2 * DATA_W){1'b0}}};

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q, state_d;
  logic [PayW-1:0]   main_q, main_d;
  logic [PayW-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PayW-1:0]   in_pay;
  logic              accept, consume;

  assign in_pay = {id_alusel_i, id_aluop_i, id_wreg_i, id_waddr_i, id_reg1_i, id_reg2_i};

  // Ready depends on registered state only, so there is no path from ex_ready_i.
  assign id_ready_o = (state_q != StFull);
  assign ex_valid_o = (state_q != StEmpty);

  assign accept  = id_valid_i & id_ready_o;
  assign consume = ex_valid_o & ex_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = (!ex_valid_o && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

    if (flush_i) begin
      // Inputs offered in the flush cycle are dropped along with the stage contents.
      state_d = StEmpty;
      main_d  = BubblePay;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            main_d  = in_pay;
          end
        end
        StOne: begin
          if (accept && consume) begin
            main_d = in_pay;
          end else if (accept) begin
            state_d = StFull;
            skid_d  = in_pay;
          end else if (consume) begin
            state_d = StEmpty;
            main_d  = BubblePay;
          end
        end
        StFull: begin
          if (consume) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = BubblePay;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      main_q  <= BubblePay;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign {ex_alusel_o, ex_aluop_o, ex_wreg_o, ex_waddr_o, ex_reg1_o, ex_reg2_o} = main_q;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_skid.sv
// Bench for id_ex_skid: a queue-based occupancy model checked every cycle against two
// instances (default counter width, and a 4-bit counter to exercise saturation), plus
// scripted scenarios with hand-computed expectations and a randomized phase.
module tb_id_ex_skid;

  localparam int unsigned PW = 81;  // 3 + 8 + 1 + 5 + 32 + 32
  localparam logic [PW-1:0] NopM = {3'd5, 8'd42, 70'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, id_valid, ex_ready;
  logic [PW-1:0] in_pay;
  logic [2:0]    id_alusel;
  logic [7:0]    id_aluop;
  logic          id_wreg;
  logic [4:0]    id_waddr;
  logic [31:0]   id_reg1, id_reg2;
  assign {id_alusel, id_aluop, id_wreg, id_waddr, id_reg1, id_reg2} = in_pay;

  logic        id_ready_m, ex_valid_m, ex_wreg_m;
  logic [2:0]  ex_alusel_m;
  logic [7:0]  ex_aluop_m;
  logic [4:0]  ex_waddr_m;
  logic [31:0] ex_reg1_m, ex_reg2_m;
  logic [15:0] cnt_m;
  logic        id_ready_s, ex_valid_s, ex_wreg_s;
  logic [2:0]  ex_alusel_s;
  logic [7:0]  ex_aluop_s;
  logic [4:0]  ex_waddr_s;
  logic [31:0] ex_reg1_s, ex_reg2_s;
  logic [3:0]  cnt_s;
  logic [PW-1:0] pay_m, pay_s;
  assign pay_m = {ex_alusel_m, ex_aluop_m, ex_wreg_m, ex_waddr_m, ex_reg1_m, ex_reg2_m};
  assign pay_s = {ex_alusel_s, ex_aluop_s, ex_wreg_s, ex_waddr_s, ex_reg1_s, ex_reg2_s};

  id_ex_skid #(.NOP_ALUSEL(5), .NOP_ALUOP(42)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .id_valid_i(id_valid), .id_ready_o(id_ready_m),
    .id_alusel_i(id_alusel), .id_aluop_i(id_aluop), .id_wreg_i(id_wreg),
    .id_waddr_i(id_waddr), .id_reg1_i(id_reg1), .id_reg2_i(id_reg2),
    .ex_valid_o(ex_valid_m), .ex_ready_i(ex_ready), .ex_alusel_o(ex_alusel_m),
    .ex_aluop_o(ex_aluop_m), .ex_wreg_o(ex_wreg_m), .ex_waddr_o(ex_waddr_m),
    .ex_reg1_o(ex_reg1_m), .ex_reg2_o(ex_reg2_m), .bubble_cnt_o(cnt_m)
  );

  id_ex_skid #(.CNT_W(4)) u_dut_small (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .id_valid_i(id_valid), .id_ready_o(id_ready_s),
    .id_alusel_i(id_alusel), .id_aluop_i(id_aluop), .id_wreg_i(id_wreg),
    .id_waddr_i(id_waddr), .id_reg1_i(id_reg1), .id_reg2_i(id_reg2),
    .ex_valid_o(ex_valid_s), .ex_ready_i(ex_ready), .ex_alusel_o(ex_alusel_s),
    .ex_aluop_o(ex_aluop_s), .ex_wreg_o(ex_wreg_s), .ex_waddr_o(ex_waddr_s),
    .ex_reg1_o(ex_reg1_s), .ex_reg2_o(ex_reg2_s), .bubble_cnt_o(cnt_s)
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of capacity two; the head is what execute sees.
  logic [PW-1:0] mq[$];
  int  mcnt = 0;
  int  mcnt_s = 0;
  bit  last_acc = 1'b0;

  initial forever begin
    bit acc, con;
    @(posedge clk);
    acc = id_valid && (mq.size() < 2);
    con = (mq.size() > 0) && ex_ready;
    last_acc = acc && !rst && !flush;
    if (rst) begin
      mq.delete();
      mcnt = 0;
      mcnt_s = 0;
    end else begin
      if (mq.size() == 0) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt_s < 15) mcnt_s++;
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back(in_pay);
      end
    end
  end

  initial forever begin
    bit ev, er;
    logic [PW-1:0] hm, hs;
    @(negedge clk);
    if (chk_en) begin
      ev = (mq.size() != 0);
      er = (mq.size() < 2);
      hm = ev ? mq[0] : NopM;
      hs = ev ? mq[0] : '0;
      check("model_main", {ex_valid_m, id_ready_m, pay_m, cnt_m},
            {ev, er, hm, 16'(mcnt)});
      check("model_small", {ex_valid_s, id_ready_s, pay_s, cnt_s},
            {ev, er, hs, 4'(mcnt_s)});
    end
  end

  function automatic logic [PW-1:0] rnd_pay();
    return PW'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [PW-1:0] mk(input logic [31:0] r1);
    logic [PW-1:0] p;
    p = rnd_pay();
    p[63:32] = r1;
    return p;
  endfunction

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset with random inputs.
    rst = 1'b1; flush = 1'($urandom); id_valid = 1'b1; ex_ready = 1'($urandom);
    in_pay = rnd_pay();
    cycle();
    chk_en = 1'b1;
    flush = 1'($urandom); in_pay = rnd_pay();
    cycle();
    check("rst_ex_valid", ex_valid_m, 0);
    check("rst_ex_aluop", ex_aluop_m, 42);
    check("rst_ex_reg1", ex_reg1_m, 0);
    check("rst_id_ready", id_ready_m, 1);
    check("rst_bubble_cnt", cnt_m, 0);
    rst = 1'b0; flush = 1'b0; id_valid = 1'b0;
    cycle();
    check("first_bubble_cnt", cnt_m, 1);

    // Streaming 1..8 back-to-back.
    ex_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      id_valid = 1'b1; in_pay = mk(i);
      cycle();
      check("stream_reg1", ex_reg1_m, i);
      check("stream_valid_ready", {ex_valid_m, id_ready_m}, 2'b11);
    end
    id_valid = 1'b0;
    cycle();
    check("stream_drain", ex_valid_m, 0);

    // Backpressure: A, B, C.
    id_valid = 1'b1; in_pay = mk(32'hA); ex_ready = 1'b1;
    cycle();
    check("bp_a_out", ex_reg1_m, 32'hA);
    in_pay = mk(32'hB); ex_ready = 1'b0;
    cycle();
    check("bp_b_skid", {ex_valid_m, id_ready_m, ex_reg1_m}, {2'b10, 32'hA});
    in_pay = mk(32'hC);
    cycle();
    check("bp_c_held", {id_ready_m, ex_reg1_m}, {1'b0, 32'hA});
    ex_ready = 1'b1;
    cycle();
    check("bp_b_out", {ex_valid_m, id_ready_m, ex_reg1_m}, {2'b11, 32'hB});
    cycle();
    check("bp_c_out", {ex_valid_m, ex_reg1_m}, {1'b1, 32'hC});
    id_valid = 1'b0;
    cycle();
    check("bp_drain", {ex_valid_m, ex_reg1_m}, {1'b0, 32'h0});

    // Flush while FULL, with C offered in the flush cycle.
    id_valid = 1'b1; in_pay = mk(32'hA1); ex_ready = 1'b0;
    cycle();
    in_pay = mk(32'hB2);
    cycle();
    check("fl_full", {ex_valid_m, id_ready_m, ex_reg1_m}, {2'b10, 32'hA1});
    in_pay = mk(32'hC3); flush = 1'b1;
    cycle();
    check("fl_bubble", {ex_valid_m, id_ready_m, ex_wreg_m, ex_alusel_m, ex_aluop_m, ex_reg1_m},
          {3'b010, 3'd5, 8'd42, 32'h0});
    flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    cycle();
    cycle();
    check("fl_nothing_left", {ex_valid_m, ex_reg1_m}, {1'b0, 32'h0});

    // Counter saturation on the 4-bit instance.
    rst = 1'b1;
    cycle();
    rst = 1'b0; id_valid = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    check("sat_small", cnt_s, 15);
    check("sat_main", cnt_m, 20);
    flush = 1'b1;
    cycle();
    check("sat_flush_small", cnt_s, 15);
    check("sat_flush_main", cnt_m, 21);
    flush = 1'b0;

    // Random phase: decode holds an unaccepted instruction until it is taken.
    for (int n = 0; n < 3000; n++) begin
      if (!(id_valid && !last_acc)) begin
        id_valid = (n < 1500) ? 1'b1 : ($urandom_range(3) != 0);
        in_pay = rnd_pay();
      end
      ex_ready = ($urandom_range(2) != 0);
      flush = ($urandom_range(49) == 0);
      rst = ($urandom_range(499) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
